ss_display_arbiter: RTL and testbench



---
 rtl/ss_display_arbiter_if.sv | 7 +
 rtl/ss_display_arbiter.sv | 94 +++++++++
 tb/tb_ss_display_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ss_display_arbiter_if.sv
// ss_display_arbiter_if: requester-side handshake and status bundle for the display arbiter.
interface ss_display_arbiter_if;
    logic       req0, req1, gnt0, gnt1, active_src, busy;
    logic [7:0] data0, data1;
    modport master (output req0, data0, req1, data1, input gnt0, gnt1, active_src, busy);
    modport slave  (input req0, data0, req1, data1, output gnt0, gnt1, active_src, busy);
endinterface

// File: rtl/ss_display_arbiter.sv
// ss_display_arbiter: round-robin owner of the two-digit seven-segment display
// with a minimum hold time and a blanked, time-multiplexed digit scan.
module ss_display_arbiter #(
    parameter int REFRESH_W    = 16,
    parameter int BLANK_CYCLES = 4,
    parameter int HOLD_CYCLES  = 12000000
) (
    input  logic CLK,
    input  logic RST_n,
    ss_display_arbiter_if.slave bus,
    output logic SS_A_n,
    output logic SS_B_n,
    output logic SS_C_n,
    output logic SS_D_n,
    output logic SS_E_n,
    output logic SS_F_n,
    output logic SS_G_n,
    output logic SS_right
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    typedef enum logic {IDLE, HOLD} state_t;
    state_t         state, state_nx;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic           grant, src, rr, gnt0, gnt1, active_src, busy;
    logic [7:0]     disp_reg, blank_cnt;
    logic [REFRESH_W-1:0] refresh;
    logic [6:0]     seg_n;
    logic [3:0]     nib;
    // rr holds the last granted source; resetting it to 1 makes req0 win the first tie
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        grant    = 1'b0;
        src      = (bus.req0 && bus.req1) ? ~rr : bus.req1;
        if (state == IDLE) begin
            grant    = bus.req0 | bus.req1;
            state_nx = grant ? HOLD : IDLE;
            hold_nx  = HW'(HOLD_CYCLES - 1);
        end else begin
            hold_nx  = hold_cnt - HW'(1);
            state_nx = (hold_cnt == '0) ? IDLE : HOLD;
        end
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            rr         <= 1'b1;
            disp_reg   <= 8'h00;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            active_src <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            gnt0     <= grant & ~src;
            gnt1     <= grant & src;
            busy     <= state_nx == HOLD;
            if (grant) begin
                rr         <= src;
                active_src <= src;
                disp_reg   <= src ? bus.data1 : bus.data0;
            end
        end
    end
    assign nib = SS_right ? disp_reg[3:0] : disp_reg[7:4];
    // segments are loaded only once per digit, at the end of the blank window
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            refresh   <= '0;
            SS_right  <= 1'b0;
            blank_cnt <= 8'(BLANK_CYCLES);
            seg_n     <= '1;
        end else begin
            refresh <= refresh + REFRESH_W'(1);
            if (&refresh) begin
                SS_right  <= ~SS_right;
                blank_cnt <= 8'(BLANK_CYCLES);
                seg_n     <= '1;
            end else if (blank_cnt != 8'd0) begin
                blank_cnt <= blank_cnt - 8'd1;
                if (blank_cnt == 8'd1) seg_n <= ~SEG[nib];
            end
        end
    end
    assign {SS_A_n, SS_B_n, SS_C_n, SS_D_n, SS_E_n, SS_F_n, SS_G_n} = seg_n;
    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.active_src = active_src;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_ss_display_arbiter.sv
// tb_ss_display_arbiter: randomized scenarios checked cycle by cycle against an
// arithmetic model of grant timing and scan phase.
module tb_ss_display_arbiter;
    localparam int RW = 4, B = 4, H = 10, P = 1 << RW;
    logic CLK = 1'b0, RST_n = 1'b0;
    logic a_n, b_n, c_n, d_n, e_n, f_n, g_n, ss_right;
    ss_display_arbiter_if bus();
    ss_display_arbiter #(.REFRESH_W(RW), .BLANK_CYCLES(B), .HOLD_CYCLES(H)) dut (
        .CLK(CLK), .RST_n(RST_n), .bus(bus.slave),
        .SS_A_n(a_n), .SS_B_n(b_n), .SS_C_n(c_n), .SS_D_n(d_n),
        .SS_E_n(e_n), .SS_F_n(f_n), .SS_G_n(g_n), .SS_right(ss_right));
    always #5 CLK = ~CLK;
    logic [6:0] lit [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int vectors = 0, miscompares = 0;
    int k, g;
    bit last, m_src;
    logic [7:0] m_disp;
    logic [6:0] m_seg;
    logic [11:0] obs;
    assign obs = {bus.gnt0, bus.gnt1, bus.busy, bus.active_src, ss_right, a_n, b_n, c_n, d_n, e_n, f_n, g_n};
    // model: k = edges since reset release, g = edge of the last grant
    function automatic logic [11:0] expv();
        return {k == g && !m_src, k == g && m_src, k >= g && k < g + H, m_src, ((k / P) % 2) == 1, m_seg};
    endfunction
    task automatic model_reset();
        k = 0; g = -1000; last = 1'b1; m_src = 1'b0; m_disp = 8'h00; m_seg = 7'h7F;
    endtask
    task automatic tick();
        int p;
        bit right;
        @(posedge CLK);
        k++;
        p = k % P;
        right = ((k / P) % 2) == 1;
        if (p < B) m_seg = 7'h7F;
        else if (p == B) m_seg = ~lit[right ? m_disp[3:0] : m_disp[7:4]];
        if (k > g + H && (bus.req0 || bus.req1)) begin
            m_src = (bus.req0 && bus.req1) ? !last : bus.req1;
            last = m_src;
            g = k;
            m_disp = m_src ? bus.data1 : bus.data0;
        end
        #1;
    endtask
    task automatic test_reset();
        bus.req0 = 0; bus.req1 = 0; bus.data0 = 8'h00; bus.data1 = 8'h00;
        RST_n = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        vectors++;
        if (obs !== expv()) begin miscompares++; $display("FAIL reset_hold_state obs=%h exp=%h", obs, expv()); end
        RST_n = 1'b1;
        repeat (24) begin
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL reset_idle k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (k == B + 1) begin
                vectors++;
                if ({a_n, b_n, c_n, d_n, e_n, f_n, g_n} !== 7'b0000001)
                    begin miscompares++; $display("FAIL reset_digit0 seg=%b want=0000001", {a_n, b_n, c_n, d_n, e_n, f_n, g_n}); end
            end
        end
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        while (k <= g + H && n < 40) begin
            tick(); n++;
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL %s_wait k=%0d obs=%h exp=%h", name, k, obs, expv()); end
        end
    endtask
    task automatic test_single();
        int ng = 0;
        wait_idle("single");
        bus.req0 = 1; bus.data0 = 8'h3A;
        repeat (60) begin
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL single k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (bus.gnt0) begin ng++; bus.req0 = 0; end
            if (k % P == B + 1 && k - (k % P) + B > g) begin
                vectors++;
                if ({a_n, b_n, c_n, d_n, e_n, f_n, g_n} !== (ss_right ? 7'b0001000 : 7'b0000110))
                    begin miscompares++; $display("FAIL single_digit right=%b seg=%b", ss_right, {a_n, b_n, c_n, d_n, e_n, f_n, g_n}); end
            end
        end
        vectors++;
        if (ng !== 1) begin miscompares++; $display("FAIL single_gnt_count got=%0d want=1", ng); end
    endtask
    task automatic test_both();
        int prev_k = -1, ng = 0;
        bit prev_src = 1'b0;
        bus.req0 = 1; bus.req1 = 1;
        repeat (60) begin
            bus.data0 = 8'($urandom); bus.data1 = 8'($urandom);
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL both k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (bus.gnt0 || bus.gnt1) begin
                ng++;
                if (prev_k >= 0) begin
                    vectors++;
                    if (k - prev_k !== H + 1 || bus.gnt1 === prev_src)
                        begin miscompares++; $display("FAIL both_spacing gap=%0d want=%0d src=%b prev=%b", k - prev_k, H + 1, bus.gnt1, prev_src); end
                end
                prev_k = k; prev_src = bus.gnt1;
            end
        end
        vectors++;
        if (ng < 5) begin miscompares++; $display("FAIL both_gnt_count got=%0d want>=5", ng); end
        bus.req0 = 0; bus.req1 = 0;
    endtask
    task automatic test_drop();
        int n = 0, ng1 = 0;
        wait_idle("drop");
        bus.req0 = 1; bus.data0 = 8'($urandom);
        while (!bus.gnt0 && n < 5) begin tick(); n++; end
        vectors++;
        if (!bus.gnt0) begin miscompares++; $display("FAIL drop_gnt0 got=0 want=1"); end
        bus.req0 = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 2) begin bus.req1 = 1; bus.data1 = 8'($urandom); end
            if (i == 6) bus.req1 = 0;
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL drop k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (bus.gnt1) ng1++;
        end
        vectors++;
        if (ng1 !== 0) begin miscompares++; $display("FAIL drop_gnt1 got=%0d want=0", ng1); end
    endtask
    task automatic test_random();
        repeat (400) begin
            bus.data0 = 8'($urandom); bus.data1 = 8'($urandom);
            if (!bus.req0) bus.req0 = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) bus.req0 = 0;
            if (!bus.req1) bus.req1 = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) bus.req1 = 0;
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL random k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (bus.gnt0) bus.req0 = 0;
            if (bus.gnt1) bus.req1 = 0;
        end
        bus.req0 = 0; bus.req1 = 0;
    endtask
    task automatic test_reset_hold();
        int n = 0, ng1 = 0;
        while (!(bus.busy && ss_right) && n < 100) begin
            bus.req0 = !bus.busy && !bus.gnt0;
            tick(); n++;
        end
        vectors++;
        if (!(bus.busy && ss_right)) begin miscompares++; $display("FAIL rsthold_setup busy=%b right=%b want=1,1", bus.busy, ss_right); end
        bus.req0 = 0;
        #2 RST_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 12'b0000_0_1111111) begin miscompares++; $display("FAIL rsthold_async obs=%h want=07f", obs); end
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        bus.req1 = 1; bus.data1 = 8'($urandom);
        repeat (30) begin
            tick();
            vectors++;
            if (obs !== expv()) begin miscompares++; $display("FAIL rsthold k=%0d obs=%h exp=%h", k, obs, expv()); end
            if (bus.gnt1) begin ng1++; bus.req1 = 0; end
        end
        vectors++;
        if (ng1 !== 1) begin miscompares++; $display("FAIL rsthold_gnt1 got=%0d want=1", ng1); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_both();
        test_drop();
        test_random();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
